enigma_controller: RTL and testbench

ENIGMA_CONTROLLER -- requirements
Module: enigma_controller

---
 rtl/enigma_controller.sv | 140 ++++++++++++++
 tb/tb_enigma_controller.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/enigma_controller.sv
// Front-end controller for an Enigma rotor core: validates rotor configuration,
// folds ASCII letters to 1..26 for the core and returns results as uppercase ASCII.
module enigma_controller #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        cfg_valid_in,
  input  logic [8:0]  cfg_rotor_select_in,
  input  logic [14:0] cfg_rotor_initial_in,
  output logic        cfg_ready_out,
  output logic        cfg_error_out,
  input  logic        char_valid_in,
  input  logic [7:0]  char_in,
  output logic        char_ready_out,
  output logic        char_valid_out,
  output logic [7:0]  char_out,
  output logic [8:0]  enc_rotor_select_out,
  output logic [14:0] enc_rotor_initial_out,
  output logic        enc_rotor_valid_out,
  output logic        enc_data_valid_out,
  output logic [4:0]  enc_data_out,
  input  logic        enc_ready_in,
  input  logic        enc_data_valid_in,
  input  logic [4:0]  enc_data_in,
  output logic        busy_out,
  output logic        error_out,
  output logic [15:0] char_count_out
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {UNCONF, CFG_PULSE, SETTLE, IDLE, ISSUE, WAIT, ERROR} state_t;

  state_t     state, state_next;
  logic [CNT_W-1:0] wait_cnt;

  // Rotor IDs must be 1..5 and pairwise distinct; every start position 0..25.
  function automatic logic cfg_is_valid(input logic [8:0] sel, input logic [14:0] pos);
    logic [2:0] a, b, c;
    a = sel[8:6];
    b = sel[5:3];
    c = sel[2:0];
    return (a != 3'd0) && (a <= 3'd5) && (b != 3'd0) && (b <= 3'd5) &&
           (c != 3'd0) && (c <= 3'd5) && (a != b) && (a != c) && (b != c) &&
           (pos[14:10] <= 5'd25) && (pos[9:5] <= 5'd25) && (pos[4:0] <= 5'd25);
  endfunction

  logic cfg_window, cfg_ok, cfg_accept, cfg_reject;
  logic char_accept, is_letter;
  logic result_in_range, result_ok, result_bad, timeout_hit;

  assign cfg_window  = (state == UNCONF) || (state == IDLE) || (state == ERROR);
  assign cfg_ok      = cfg_is_valid(cfg_rotor_select_in, cfg_rotor_initial_in);
  assign cfg_accept  = cfg_window && cfg_valid_in && cfg_ok;
  assign cfg_reject  = cfg_window && cfg_valid_in && !cfg_ok;
  assign char_accept = char_valid_in && char_ready_out;
  assign is_letter   = ((char_in >= 8'h41) && (char_in <= 8'h5A)) ||
                       ((char_in >= 8'h61) && (char_in <= 8'h7A));

  assign result_in_range = (enc_data_in != 5'd0) && (enc_data_in <= 5'd26);
  assign result_ok       = (state == WAIT) && enc_data_valid_in && result_in_range;
  assign result_bad      = (state == WAIT) && enc_data_valid_in && !result_in_range;
  assign timeout_hit     = (state == WAIT) && !enc_data_valid_in &&
                           (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) state <= UNCONF;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      UNCONF, ERROR: if (cfg_accept) state_next = CFG_PULSE;
      CFG_PULSE:     state_next = SETTLE;
      SETTLE:        state_next = IDLE;
      IDLE: begin
        if (cfg_accept)                    state_next = CFG_PULSE;
        else if (char_accept && is_letter) state_next = ISSUE;
      end
      ISSUE:         if (enc_ready_in) state_next = WAIT;
      WAIT: begin
        if (result_ok)                      state_next = IDLE;
        else if (result_bad || timeout_hit) state_next = ERROR;
      end
      default:       state_next = UNCONF;
    endcase
  end

  // A pending config request blocks character acceptance in IDLE.
  always_comb begin
    cfg_ready_out       = cfg_window;
    char_ready_out      = (state == IDLE) && !cfg_valid_in;
    busy_out            = !cfg_window;
    enc_rotor_valid_out = (state == CFG_PULSE);
    enc_data_valid_out  = (state == ISSUE);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      cfg_error_out         <= 1'b0;
      char_valid_out        <= 1'b0;
      char_out              <= 8'h00;
      enc_rotor_select_out  <= 9'd0;
      enc_rotor_initial_out <= 15'd0;
      enc_data_out          <= 5'd0;
      error_out             <= 1'b0;
      char_count_out        <= 16'd0;
      wait_cnt              <= '0;
    end else begin
      cfg_error_out  <= cfg_reject;
      char_valid_out <= 1'b0;
      if (cfg_accept) begin
        enc_rotor_select_out  <= cfg_rotor_select_in;
        enc_rotor_initial_out <= cfg_rotor_initial_in;
        char_count_out        <= 16'd0;
        error_out             <= 1'b0;
      end
      // Upper and lower case share the low five bits, which give 1..26 directly.
      if (char_accept) begin
        if (is_letter) begin
          enc_data_out <= char_in[4:0];
        end else begin
          char_out       <= char_in;
          char_valid_out <= 1'b1;
        end
      end
      if (state == ISSUE && enc_ready_in) wait_cnt <= '0;
      else if (state == WAIT)             wait_cnt <= wait_cnt + 1'b1;
      if (result_ok) begin
        char_out       <= 8'h40 + {3'b000, enc_data_in};
        char_valid_out <= 1'b1;
        if (char_count_out != 16'hFFFF) char_count_out <= char_count_out + 16'd1;
      end
      if (result_bad || timeout_hit) error_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_enigma_controller.sv
// Directed bench for enigma_controller; returned characters are checked against
// a scoreboard queue filled when the stimulus that causes them is driven.
module tb_enigma_controller;

  localparam int TIMEOUT = 16;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        cfg_valid_in;
  logic [8:0]  cfg_rotor_select_in;
  logic [14:0] cfg_rotor_initial_in;
  logic        cfg_ready_out;
  logic        cfg_error_out;
  logic        char_valid_in;
  logic [7:0]  char_in;
  logic        char_ready_out;
  logic        char_valid_out;
  logic [7:0]  char_out;
  logic [8:0]  enc_rotor_select_out;
  logic [14:0] enc_rotor_initial_out;
  logic        enc_rotor_valid_out;
  logic        enc_data_valid_out;
  logic [4:0]  enc_data_out;
  logic        enc_ready_in;
  logic        enc_data_valid_in;
  logic [4:0]  enc_data_in;
  logic        busy_out;
  logic        error_out;
  logic [15:0] char_count_out;

  int        n_checks = 0;
  int        n_fail   = 0;
  bit        mon_en   = 1'b0;
  logic [7:0] sb[$];

  always #5 clk_in = ~clk_in;

  enigma_controller #(.TIMEOUT(TIMEOUT)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .cfg_valid_in(cfg_valid_in), .cfg_rotor_select_in(cfg_rotor_select_in),
    .cfg_rotor_initial_in(cfg_rotor_initial_in), .cfg_ready_out(cfg_ready_out),
    .cfg_error_out(cfg_error_out), .char_valid_in(char_valid_in), .char_in(char_in),
    .char_ready_out(char_ready_out), .char_valid_out(char_valid_out), .char_out(char_out),
    .enc_rotor_select_out(enc_rotor_select_out), .enc_rotor_initial_out(enc_rotor_initial_out),
    .enc_rotor_valid_out(enc_rotor_valid_out), .enc_data_valid_out(enc_data_valid_out),
    .enc_data_out(enc_data_out), .enc_ready_in(enc_ready_in),
    .enc_data_valid_in(enc_data_valid_in), .enc_data_in(enc_data_in),
    .busy_out(busy_out), .error_out(error_out), .char_count_out(char_count_out)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
    #1;
  endtask

  task automatic applyStimulus(input logic cv, input logic [8:0] sel, input logic [14:0] pos,
                               input logic chv, input logic [7:0] ch);
    cfg_valid_in         = cv;
    cfg_rotor_select_in  = sel;
    cfg_rotor_initial_in = pos;
    char_valid_in        = chv;
    char_in              = ch;
    tick();
    cfg_valid_in  = 1'b0;
    char_valid_in = 1'b0;
  endtask

  // Every cycle: a character is emitted exactly when the scoreboard holds one.
  always @(negedge clk_in) begin
    if (mon_en) begin
      if (sb.size() > 0) begin
        checkOutput("char_valid_out", {31'd0, char_valid_out}, 32'd1);
        checkOutput("char_out", {24'd0, char_out}, {24'd0, sb.pop_front()});
      end else begin
        checkOutput("no_stray_char", {31'd0, char_valid_out}, 32'd0);
      end
    end
  end

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n_in = 1'b0; cfg_valid_in = 1'b0; cfg_rotor_select_in = '0; cfg_rotor_initial_in = '0;
    char_valid_in = 1'b0; char_in = '0; enc_ready_in = 1'b0; enc_data_valid_in = 1'b0;
    enc_data_in = '0;
    repeat (2) tick();
    checkOutput("rst_cfg_ready", cfg_ready_out, 1);
    checkOutput("rst_char_ready", char_ready_out, 0);
    checkOutput("rst_busy", busy_out, 0);
    checkOutput("rst_error", error_out, 0);
    checkOutput("rst_cfg_error", cfg_error_out, 0);
    checkOutput("rst_rotor_valid", enc_rotor_valid_out, 0);
    checkOutput("rst_data_valid", enc_data_valid_out, 0);
    checkOutput("rst_count", char_count_out, 0);
    checkOutput("rst_rotor_sel", enc_rotor_select_out, 0);
    mon_en   = 1'b1;
    rst_n_in = 1'b1;
    tick();

    // Rejected configs: duplicate ID, position 26, ID 6.
    applyStimulus(1'b1, 9'o113, 15'h0000, 1'b0, 8'h00);
    checkOutput("dup_cfg_error", cfg_error_out, 1);
    checkOutput("dup_rotor_valid", enc_rotor_valid_out, 0);
    checkOutput("dup_cfg_ready", cfg_ready_out, 1);
    checkOutput("dup_busy", busy_out, 0);
    tick();
    checkOutput("dup_pulse_end", cfg_error_out, 0);
    checkOutput("dup_rotor_valid2", enc_rotor_valid_out, 0);
    applyStimulus(1'b1, 9'o123, 15'd26, 1'b0, 8'h00);
    checkOutput("pos26_cfg_error", cfg_error_out, 1);
    checkOutput("pos26_rotor_valid", enc_rotor_valid_out, 0);
    applyStimulus(1'b1, 9'o623, 15'h0000, 1'b0, 8'h00);
    checkOutput("id6_cfg_error", cfg_error_out, 1);
    checkOutput("id6_sel_unchanged", enc_rotor_select_out, 0);
    tick();

    // Valid config and load sequence.
    applyStimulus(1'b1, 9'o123, 15'h0000, 1'b0, 8'h00);
    checkOutput("cfg_error_ok", cfg_error_out, 0);
    checkOutput("cfg_rotor_valid", enc_rotor_valid_out, 1);
    checkOutput("cfg_rotor_sel", enc_rotor_select_out, 9'o123);
    checkOutput("cfg_busy", busy_out, 1);
    checkOutput("cfg_ready_low", cfg_ready_out, 0);
    tick();
    checkOutput("settle_rotor_valid", enc_rotor_valid_out, 0);
    checkOutput("settle_char_ready", char_ready_out, 0);
    tick();
    checkOutput("idle_char_ready", char_ready_out, 1);
    checkOutput("idle_busy", busy_out, 0);

    // Non-letter passes straight through.
    sb.push_back(8'h20);
    applyStimulus(1'b0, 9'd0, 15'd0, 1'b1, 8'h20);
    checkOutput("space_no_core", enc_data_valid_out, 0);
    checkOutput("space_count", char_count_out, 0);
    checkOutput("space_char_ready", char_ready_out, 1);

    // Config wins over a simultaneous character.
    applyStimulus(1'b1, 9'o345, {5'd1, 5'd2, 5'd25}, 1'b1, 8'h51);
    checkOutput("win_rotor_valid", enc_rotor_valid_out, 1);
    checkOutput("win_no_core", enc_data_valid_out, 0);
    checkOutput("win_rotor_init", enc_rotor_initial_out, {5'd1, 5'd2, 5'd25});
    repeat (2) tick();
    checkOutput("win_idle", char_ready_out, 1);

    // 'b' held while the core stalls three cycles, result 5 returns 'E'.
    enc_ready_in = 1'b0;
    applyStimulus(1'b0, 9'd0, 15'd0, 1'b1, 8'h62);
    for (int i = 0; i < 4; i++) begin
      checkOutput("b_data_valid", enc_data_valid_out, 1);
      checkOutput("b_data", enc_data_out, 2);
      if (i == 3) enc_ready_in = 1'b1;
      tick();
    end
    enc_ready_in = 1'b0;
    checkOutput("b_handoff_drop", enc_data_valid_out, 0);
    checkOutput("b_wait_busy", busy_out, 1);
    repeat (6) tick();
    enc_data_valid_in = 1'b1;
    enc_data_in       = 5'd5;
    sb.push_back(8'h45);
    tick();
    enc_data_valid_in = 1'b0;
    checkOutput("b_count", char_count_out, 1);
    checkOutput("b_char_ready", char_ready_out, 1);

    // Core result outside WAIT is ignored.
    enc_data_valid_in = 1'b1;
    enc_data_in       = 5'd3;
    tick();
    enc_data_valid_in = 1'b0;
    checkOutput("stray_count", char_count_out, 1);
    checkOutput("stray_busy", busy_out, 0);

    // 'A' with core ready at once; result 26 returns 'Z'.
    enc_ready_in = 1'b1;
    applyStimulus(1'b0, 9'd0, 15'd0, 1'b1, 8'h41);
    checkOutput("A_data", enc_data_out, 1);
    tick();
    enc_ready_in = 1'b0;
    checkOutput("A_data_valid_drop", enc_data_valid_out, 0);
    enc_data_valid_in = 1'b1;
    enc_data_in       = 5'd26;
    sb.push_back(8'h5A);
    tick();
    enc_data_valid_in = 1'b0;
    checkOutput("A_count", char_count_out, 2);

    // Reset in WAIT drops the character; a late result is ignored.
    enc_ready_in = 1'b1;
    applyStimulus(1'b0, 9'd0, 15'd0, 1'b1, 8'h64);
    tick();
    enc_ready_in = 1'b0;
    tick();
    checkOutput("d_wait_busy", busy_out, 1);
    rst_n_in = 1'b0;
    tick();
    rst_n_in = 1'b1;
    checkOutput("mid_rst_busy", busy_out, 0);
    checkOutput("mid_rst_cfg_ready", cfg_ready_out, 1);
    checkOutput("mid_rst_data", enc_data_out, 0);
    checkOutput("mid_rst_data_valid", enc_data_valid_out, 0);
    checkOutput("mid_rst_sel", enc_rotor_select_out, 0);
    checkOutput("mid_rst_init", enc_rotor_initial_out, 0);
    checkOutput("mid_rst_count", char_count_out, 0);
    checkOutput("mid_rst_char_out", char_out, 0);
    enc_data_valid_in = 1'b1;
    enc_data_in       = 5'd4;
    tick();
    enc_data_valid_in = 1'b0;
    checkOutput("late_busy", busy_out, 0);
    checkOutput("late_char_ready", char_ready_out, 0);
    checkOutput("late_count", char_count_out, 0);

    // Out-of-range core result sets the error.
    applyStimulus(1'b1, 9'o215, 15'h0000, 1'b0, 8'h00);
    repeat (2) tick();
    enc_ready_in = 1'b1;
    applyStimulus(1'b0, 9'd0, 15'd0, 1'b1, 8'h7A);
    tick();
    enc_ready_in      = 1'b0;
    enc_data_valid_in = 1'b1;
    enc_data_in       = 5'd27;
    tick();
    enc_data_valid_in = 1'b0;
    checkOutput("range_error", error_out, 1);
    checkOutput("range_char_ready", char_ready_out, 0);
    checkOutput("range_busy", busy_out, 0);

    // ERROR ignores characters and invalid configs; a valid config recovers.
    applyStimulus(1'b0, 9'd0, 15'd0, 1'b1, 8'h78);
    checkOutput("err_no_core", enc_data_valid_out, 0);
    applyStimulus(1'b1, 9'o113, 15'h0000, 1'b0, 8'h00);
    checkOutput("err_bad_cfg_pulse", cfg_error_out, 1);
    checkOutput("err_sticky", error_out, 1);
    applyStimulus(1'b1, 9'o512, {5'd25, 5'd0, 5'd7}, 1'b0, 8'h00);
    checkOutput("err_clear", error_out, 0);
    checkOutput("err_cfg_pulse", enc_rotor_valid_out, 1);
    checkOutput("err_cfg_init", enc_rotor_initial_out, {5'd25, 5'd0, 5'd7});
    repeat (2) tick();
    checkOutput("err_idle", char_ready_out, 1);

    // Silent core: error exactly TIMEOUT cycles after handoff.
    enc_ready_in = 1'b1;
    applyStimulus(1'b0, 9'd0, 15'd0, 1'b1, 8'h63);
    tick();
    enc_ready_in = 1'b0;
    repeat (TIMEOUT - 1) tick();
    checkOutput("to_not_yet", error_out, 0);
    checkOutput("to_busy", busy_out, 1);
    tick();
    checkOutput("to_error", error_out, 1);
    checkOutput("to_char_ready", char_ready_out, 0);
    applyStimulus(1'b1, 9'o123, 15'h0000, 1'b0, 8'h00);
    checkOutput("to_cfg_clear", error_out, 0);
    repeat (2) tick();
    checkOutput("to_idle", char_ready_out, 1);

    checkOutput("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
